// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: write-back source/load encodings and the default reset PC shared by the write-back stage.
package wb_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  typedef enum logic [1:0] {WS_ALU = 2'd0, WS_LD = 2'd1, WS_PC8 = 2'd2, WS_RSV = 2'd3} wsel_e;
  typedef enum logic [2:0] {LD_LW = 3'd0, LD_LH = 3'd1, LD_LHU = 3'd2, LD_LB = 3'd3, LD_LBU = 3'd4} ld_e;
endpackage

// File: rtl/wb_stage_load_ext.sv
// load_ext: selects and sign/zero-extends a half or byte from an aligned memory word.
module load_ext
  import wb_stage_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [15:0] w_h;
  logic [7:0]  w_b;
  always_comb begin
    w_h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    w_b  = rdata[{addr_lo, 3'b000} +: 8];
    data = ld_type == LD_LH  ? {{16{w_h[15]}}, w_h} :
           ld_type == LD_LHU ? {16'h0, w_h} :
           ld_type == LD_LB  ? {{24{w_b[7]}}, w_b} :
           ld_type == LD_LBU ? {24'h0, w_b} : rdata;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back register, GPR write data/enable, misaligned-load flag and retire counter.
// Define WB_TRACE_EN to print one line per GPR write.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_wen,
  input  logic [4:0]  m_wadd,
  input  logic [1:0]  m_wsel,
  input  logic [2:0]  m_ld_type,
  input  logic [1:0]  m_addr_lo,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_rdata,
  output logic [31:0] wpc,
  output logic [4:0]  wadd,
  output logic        GRFwen,
  output logic [31:0] wdat,
  output logic        w_ade,
  output logic [31:0] retire_cnt
);
  logic        r_valid, r_wen;
  logic [31:0] r_pc, r_alu, r_rdata, r_cnt;
  logic [4:0]  r_wadd;
  logic [1:0]  r_wsel, r_alo;
  logic [2:0]  r_ldt;
  logic [31:0] w_ld;
  logic        w_is_lw, w_is_h;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_wen   <= 1'b0;
      r_wadd  <= 5'd0;
      r_wsel  <= 2'd0;
      r_ldt   <= 3'd0;
      r_alo   <= 2'd0;
      r_alu   <= 32'd0;
      r_rdata <= 32'd0;
      r_cnt   <= 32'd0;
    end else begin
      r_valid <= m_valid;
      r_pc    <= m_pc;
      r_wen   <= m_wen;
      r_wadd  <= m_wadd;
      r_wsel  <= m_wsel;
      r_ldt   <= m_ld_type;
      r_alo   <= m_addr_lo;
      r_alu   <= m_alu;
      r_rdata <= m_rdata;
      r_cnt   <= r_cnt + {31'd0, r_valid};
    end
  end
  load_ext u_ext (.ld_type(r_ldt), .addr_lo(r_alo), .rdata(r_rdata), .data(w_ld));
  always_comb begin
    w_is_lw    = r_ldt == LD_LW || r_ldt > LD_LBU;
    w_is_h     = r_ldt == LD_LH || r_ldt == LD_LHU;
    w_ade      = r_valid & r_wen & (r_wsel == WS_LD) & (w_is_lw ? |r_alo : w_is_h & r_alo[0]);
    wdat       = r_wsel == WS_LD ? w_ld : r_wsel == WS_PC8 ? r_pc + 32'd8 : r_alu;
    wpc        = r_pc;
    wadd       = r_wadd;
    retire_cnt = r_cnt;
    // rst on the same edge squashes the registered instruction's write
    GRFwen     = r_valid & r_wen & |r_wadd & ~w_ade & ~rst;
  end
`ifdef WB_TRACE_EN
  always @(posedge clk)
    if (GRFwen) $display("%0t@%h: $%0d <= %h", $time, wpc, wadd, wdat);
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_wb_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        m_valid = 1'b0, m_wen = 1'b0;
  logic [31:0] m_pc = 32'd0, m_alu = 32'd0, m_rdata = 32'd0;
  logic [4:0]  m_wadd = 5'd0;
  logic [1:0]  m_wsel = 2'd0, m_addr_lo = 2'd0;
  logic [2:0]  m_ld_type = 3'd0;
  logic [31:0] wpc, wdat, retire_cnt;
  logic [4:0]  wadd;
  logic        GRFwen, w_ade;
  typedef struct {
    string       name;
    logic        grf, ade;
    logic [4:0]  wadd;
    logic [31:0] wdat, wpc, cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [31:0] cnt_model = 32'd0;
  wb_stage dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_pc(m_pc), .m_wen(m_wen), .m_wadd(m_wadd),
    .m_wsel(m_wsel), .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo), .m_alu(m_alu),
    .m_rdata(m_rdata), .wpc(wpc), .wadd(wadd), .GRFwen(GRFwen), .wdat(wdat),
    .w_ade(w_ade), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic step(input string n, input logic r, input logic v, input logic [31:0] pc,
                      input logic we, input logic [4:0] wa, input logic [1:0] ws,
                      input logic [2:0] lt, input logic [1:0] al, input logic [31:0] alu,
                      input logic [31:0] rd, input logic eg, input logic ea, input logic [31:0] ed);
    exp_t e;
    @(negedge clk);
    rst = r; m_valid = v; m_pc = pc; m_wen = we; m_wadd = wa; m_wsel = ws;
    m_ld_type = lt; m_addr_lo = al; m_alu = alu; m_rdata = rd;
    e.name = n;
    if (r) begin
      e.grf = 1'b0; e.ade = 1'b0; e.wadd = 5'd0; e.wdat = 32'd0; e.wpc = 32'h0000_3000; e.cnt = 32'd0;
      cnt_model = 32'd0;
    end else begin
      e.grf = eg; e.ade = ea; e.wadd = wa; e.wdat = ed; e.wpc = pc; e.cnt = cnt_model;
      cnt_model = cnt_model + {31'd0, v};
    end
    q.push_back(e);
    if (r) begin
      #1 chk({n, "_squash_grfwen"}, {31'd0, GRFwen}, 32'd0);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.name, "_grfwen"}, {31'd0, GRFwen}, {31'd0, e.grf});
        chk({e.name, "_ade"}, {31'd0, w_ade}, {31'd0, e.ade});
        chk({e.name, "_wadd"}, {27'd0, wadd}, {27'd0, e.wadd});
        chk({e.name, "_wdat"}, wdat, e.wdat);
        chk({e.name, "_wpc"}, wpc, e.wpc);
        chk({e.name, "_cnt"}, retire_cnt, e.cnt);
      end
    end
  end
  initial begin
    @(negedge clk);
    step("rst",      1, 0, 32'h0,         0, 5'd0,  2'd0, 3'd0, 2'd0, 32'h0,         32'h0,         0, 0, 32'h0);
    step("lb",       0, 1, 32'h0000_3000, 1, 5'd8,  2'd1, 3'd3, 2'd2, 32'h0,         32'h1280_3456, 1, 0, 32'hFFFF_FF80);
    step("lbu",      0, 1, 32'h0000_3004, 1, 5'd8,  2'd1, 3'd4, 2'd2, 32'h0,         32'h1280_3456, 1, 0, 32'h0000_0080);
    step("lh_mis",   0, 1, 32'h0000_3008, 1, 5'd9,  2'd1, 3'd1, 2'd1, 32'h0,         32'h1280_3456, 0, 1, 32'h0000_3456);
    step("lhu",      0, 1, 32'h0000_300C, 1, 5'd10, 2'd1, 3'd2, 2'd2, 32'h0,         32'h8001_0000, 1, 0, 32'h0000_8001);
    step("jal",      0, 1, 32'h0000_3010, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h1234_5678, 32'h0,         1, 0, 32'h0000_3018);
    step("alu_r0",   0, 1, 32'h0000_3014, 1, 5'd0,  2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0,         0, 0, 32'hDEAD_BEEF);
    step("wsel3",    0, 1, 32'h0000_3018, 1, 5'd5,  2'd3, 3'd0, 2'd0, 32'h1122_3344, 32'h5555_5555, 1, 0, 32'h1122_3344);
    step("lw",       0, 1, 32'h0000_301C, 1, 5'd6,  2'd1, 3'd0, 2'd0, 32'h0,         32'hCAFE_BABE, 1, 0, 32'hCAFE_BABE);
    step("lw_mis",   0, 1, 32'h0000_3020, 1, 5'd6,  2'd1, 3'd0, 2'd2, 32'h0,         32'hCAFE_BABE, 0, 1, 32'hCAFE_BABE);
    step("bubble",   0, 0, 32'h0000_3024, 1, 5'd7,  2'd0, 3'd0, 2'd0, 32'h0000_0055, 32'h0,         0, 0, 32'h0000_0055);
    step("pc8_wrap", 0, 1, 32'hFFFF_FFFC, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0,         32'h0,         1, 0, 32'h0000_0004);
    step("lb_b0",    0, 1, 32'h0000_3028, 1, 5'd12, 2'd1, 3'd3, 2'd0, 32'h0,         32'h1280_3456, 1, 0, 32'h0000_0056);
    step("lh_inv",   0, 0, 32'h0000_302C, 1, 5'd13, 2'd1, 3'd1, 2'd1, 32'h0,         32'h1280_3456, 0, 0, 32'h0000_3456);
    step("ld7_mis",  0, 1, 32'h0000_3030, 1, 5'd14, 2'd1, 3'd7, 2'd1, 32'h0,         32'hA5A5_0F0F, 0, 1, 32'hA5A5_0F0F);
    step("nowen",    0, 1, 32'h0000_3034, 0, 5'd15, 2'd0, 3'd0, 2'd0, 32'h0000_0077, 32'h0,         0, 0, 32'h0000_0077);
    step("pre_rst",  0, 1, 32'h0000_3038, 1, 5'd3,  2'd0, 3'd0, 2'd0, 32'h0000_0001, 32'h0,         1, 0, 32'h0000_0001);
    step("mid_rst",  1, 0, 32'h0,         0, 5'd0,  2'd0, 3'd0, 2'd0, 32'h0,         32'h0,         0, 0, 32'h0);
    step("post_rst", 0, 1, 32'h0000_3040, 1, 5'd4,  2'd0, 3'd0, 2'd0, 32'h0000_0002, 32'h0,         1, 0, 32'h0000_0002);
    step("idle",     0, 0, 32'h0000_3044, 0, 5'd0,  2'd0, 3'd0, 2'd0, 32'h0,         32'h0,         0, 0, 32'h0);
    step("idle2",    0, 0, 32'h0000_3048, 0, 5'd0,  2'd0, 3'd0, 2'd0, 32'h0,         32'h0,         0, 0, 32'h0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
